// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: walks tiles x kernels x channel groups,
// issuing DRAM refills, PE weight-row loads, bias fetches and accumulate phases.
module conv_layer_sequencer #(
  parameter int unsigned CH_W     = 6,
  parameter int unsigned KER_W    = 13,
  parameter int unsigned TILE_W   = 9,
  parameter int unsigned WADDR_W  = 13,
  parameter int unsigned LOAD_CYC = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CH_W-1:0]     cfg_max_ch,
  input  logic [KER_W-1:0]    cfg_max_ker,
  input  logic [TILE_W-1:0]   cfg_max_tile,
  input  logic [KER_W-1:0]    cfg_ker_per_buf,
  input  logic [TILE_W-1:0]   cfg_tile_per_buf,
  input  logic                dram_done,
  input  logic                acc_done,
  input  logic                out_ready,
  output logic                dram_req,
  output logic                accum_en,
  output logic                busy,
  output logic                layer_done,
  output logic [LOAD_CYC-1:0] ker_load,
  output logic [WADDR_W-1:0]  w_addr,
  output logic                w_en,
  output logic [KER_W-1:0]    bias_addr,
  output logic                bias_en,
  output logic [KER_W-1:0]    ker_idx,
  output logic [TILE_W-1:0]   tile_idx,
  output logic                ker_change,
  output logic                tile_change
);

  localparam int unsigned LC_W = $clog2(LOAD_CYC + 1);
  localparam logic [LOAD_CYC-1:0] KL_MSB = LOAD_CYC'(1) << (LOAD_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAM, S_LOAD, S_ACCUM, S_KER_END, S_TILE_END, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [CH_W-1:0]     cfg_ch, ch;
  logic [KER_W-1:0]    cfg_ker, cfg_kpb, kcnt;
  logic [TILE_W-1:0]   cfg_tile, cfg_tpb, tcnt;
  logic [LC_W-1:0]     lcnt;
  logic                end_seen;
  logic                last_ch, last_ker, last_tile, kbuf_full, refetch, load_last;

  // Loop-boundary decodes against the latched layer configuration
  assign last_ch   = (ch == cfg_ch - CH_W'(1));
  assign last_ker  = (ker_idx == cfg_ker - KER_W'(1));
  assign last_tile = (tile_idx == cfg_tile - TILE_W'(1));
  assign kbuf_full = (kcnt == cfg_kpb - KER_W'(1));
  assign refetch   = (tcnt == cfg_tpb - TILE_W'(1)) || (cfg_ker > cfg_kpb);
  assign load_last = (lcnt == LC_W'(LOAD_CYC));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; end states re-entered while waiting only watch out_ready
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_DRAM;
      S_DRAM:  if (dram_done) state_nxt = S_LOAD;
      S_LOAD:  if (load_last) state_nxt = S_ACCUM;
      S_ACCUM: if (acc_done) state_nxt = last_ch ? S_KER_END : S_LOAD;
      S_KER_END: begin
        if (end_seen) begin
          if (out_ready) state_nxt = S_DRAM;
        end else if (last_ker) begin
          state_nxt = S_TILE_END;
        end else if (kbuf_full) begin
          if (out_ready) state_nxt = S_DRAM;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      S_TILE_END: begin
        if (end_seen) begin
          if (out_ready) state_nxt = S_DRAM;
        end else if (last_tile) begin
          state_nxt = S_DONE;
        end else if (refetch) begin
          if (out_ready) state_nxt = S_DRAM;
        end else begin
          state_nxt = S_LOAD;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode from current state and load-phase position
  always_comb begin
    dram_req    = 1'b0;
    accum_en    = 1'b0;
    layer_done  = 1'b0;
    w_en        = 1'b0;
    bias_en     = 1'b0;
    ker_change  = 1'b0;
    tile_change = 1'b0;
    busy        = (state != S_IDLE);
    bias_addr   = ker_idx;
    case (state)
      S_DRAM:     dram_req    = 1'b1;
      S_LOAD: begin
        w_en    = (lcnt < LC_W'(LOAD_CYC));
        bias_en = (lcnt == '0) && (ch == '0);
      end
      S_ACCUM:    accum_en    = 1'b1;
      S_KER_END:  ker_change  = !end_seen;
      S_TILE_END: tile_change = !end_seen;
      S_DONE:     layer_done  = 1'b1;
      default: ;
    endcase
  end

  // Loop counters, weight address, row-load strobe and config capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_ch   <= '0;
      cfg_ker  <= '0;
      cfg_tile <= '0;
      cfg_kpb  <= '0;
      cfg_tpb  <= '0;
      ch       <= '0;
      ker_idx  <= '0;
      tile_idx <= '0;
      kcnt     <= '0;
      tcnt     <= '0;
      w_addr   <= '0;
      lcnt     <= '0;
      ker_load <= '0;
      end_seen <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          cfg_ch   <= (cfg_max_ch == '0)       ? CH_W'(1)   : cfg_max_ch;
          cfg_ker  <= (cfg_max_ker == '0)      ? KER_W'(1)  : cfg_max_ker;
          cfg_tile <= (cfg_max_tile == '0)     ? TILE_W'(1) : cfg_max_tile;
          cfg_kpb  <= (cfg_ker_per_buf == '0)  ? KER_W'(1)  : cfg_ker_per_buf;
          cfg_tpb  <= (cfg_tile_per_buf == '0) ? TILE_W'(1) : cfg_tile_per_buf;
          ch       <= '0;
          ker_idx  <= '0;
          tile_idx <= '0;
          kcnt     <= '0;
          tcnt     <= '0;
        end
        S_LOAD: if (w_en) w_addr <= w_addr + WADDR_W'(1);
        S_ACCUM: if (acc_done && !last_ch) ch <= ch + CH_W'(1);
        S_KER_END: if (!end_seen) begin
          ch <= '0;
          if (!last_ker) begin
            ker_idx <= ker_idx + KER_W'(1);
            kcnt    <= kbuf_full ? '0 : kcnt + KER_W'(1);
          end
        end
        S_TILE_END: if (!end_seen) begin
          ker_idx <= '0;
          kcnt    <= '0;
          if (!last_tile) begin
            tile_idx <= tile_idx + TILE_W'(1);
            if (refetch) begin
              tcnt <= '0;
            end else begin
              tcnt   <= tcnt + TILE_W'(1);
              w_addr <= '0;
            end
          end
        end
        default: ;
      endcase
      if (state_nxt == S_DRAM && state != S_DRAM) w_addr <= '0;
      lcnt     <= (state == S_LOAD && state_nxt == S_LOAD) ? lcnt + LC_W'(1) : '0;
      ker_load <= w_en ? ((lcnt == '0) ? KL_MSB : (ker_load >> 1)) : '0;
      end_seen <= (state == S_KER_END || state == S_TILE_END) && (state_nxt == state);
    end
  end

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: directed cycle checks plus randomized layers
// compared against a nested-loop event model of the layer walk.
module tb_conv_layer_sequencer;

  localparam int LC = 3;
  localparam int EV_DRAM = 1, EV_LOAD = 2, EV_KCHG = 3, EV_TCHG = 4, EV_DONE = 5;

  logic        clk, rst_n, start;
  logic [5:0]  cfg_max_ch;
  logic [12:0] cfg_max_ker, cfg_ker_per_buf;
  logic [8:0]  cfg_max_tile, cfg_tile_per_buf;
  logic        dram_done, acc_done, out_ready;
  logic        dram_req, accum_en, busy, layer_done, w_en, bias_en, ker_change, tile_change;
  logic [2:0]  ker_load;
  logic [12:0] w_addr, bias_addr, ker_idx;
  logic [8:0]  tile_idx;

  int n_chk = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  conv_layer_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_max_ch(cfg_max_ch), .cfg_max_ker(cfg_max_ker), .cfg_max_tile(cfg_max_tile),
    .cfg_ker_per_buf(cfg_ker_per_buf), .cfg_tile_per_buf(cfg_tile_per_buf),
    .dram_done(dram_done), .acc_done(acc_done), .out_ready(out_ready),
    .dram_req(dram_req), .accum_en(accum_en), .busy(busy), .layer_done(layer_done),
    .ker_load(ker_load), .w_addr(w_addr), .w_en(w_en), .bias_addr(bias_addr),
    .bias_en(bias_en), .ker_idx(ker_idx), .tile_idx(tile_idx),
    .ker_change(ker_change), .tile_change(tile_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({dram_req, accum_en, busy, layer_done, ker_load, w_addr, w_en,
                bias_addr, bias_en, ker_idx, tile_idx, ker_change, tile_change});
  endfunction

  function automatic logic [63:0] mk_ev(input int ty, input int tl, input int kr,
                                        input int wa, input int ba, input bit bi);
    return {4'(ty), 12'(tl), 16'(kr), 16'(wa), 15'(ba), bi};
  endfunction

  function automatic int eff(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic set_cfg(input int c, input int k, input int t, input int kpb, input int tpb);
    cfg_max_ch       = 6'(c);
    cfg_max_ker      = 13'(k);
    cfg_max_tile     = 9'(t);
    cfg_ker_per_buf  = 13'(kpb);
    cfg_tile_per_buf = 9'(tpb);
  endtask

  task automatic zero_inputs();
    start = 1'b0; dram_done = 1'b0; acc_done = 1'b0; out_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
  endtask

  // Expected ordered event list for one full layer
  task automatic build_model(input int c0, input int k0, input int t0, input int kpb0, input int tpb0);
    int c, k, t, kpb, tpb, wa, kc, tc;
    c = eff(c0); k = eff(k0); t = eff(t0); kpb = eff(kpb0); tpb = eff(tpb0);
    wa = 0; kc = 0; tc = 0;
    exp_q.delete();
    exp_q.push_back(mk_ev(EV_DRAM, 0, 0, 0, 0, 1'b0));
    for (int tt = 0; tt < t; tt++) begin
      for (int kk = 0; kk < k; kk++) begin
        for (int cc = 0; cc < c; cc++) begin
          exp_q.push_back(mk_ev(EV_LOAD, tt, kk, wa, kk, cc == 0));
          wa = (wa + LC) % 8192;
        end
        exp_q.push_back(mk_ev(EV_KCHG, tt, kk, 0, 0, 1'b0));
        if (kk < k - 1) begin
          if (kc == kpb - 1) begin
            kc = 0; wa = 0;
            exp_q.push_back(mk_ev(EV_DRAM, 0, 0, 0, 0, 1'b0));
          end else begin
            kc++;
          end
        end
      end
      exp_q.push_back(mk_ev(EV_TCHG, tt, k - 1, 0, 0, 1'b0));
      kc = 0;
      if (tt < t - 1) begin
        wa = 0;
        if (tc == tpb - 1 || k > kpb) begin
          tc = 0;
          exp_q.push_back(mk_ev(EV_DRAM, 0, 0, 0, 0, 1'b0));
        end else begin
          tc++;
        end
      end
    end
    exp_q.push_back(mk_ev(EV_DONE, t - 1, 0, 0, 0, 1'b0));
  endtask

  // Cycle-exact check of one LOAD phase, ending on the first ACCUM cycle
  task automatic check_load(input int wa0, input bit bias);
    for (int j = 0; j <= LC; j++) begin
      chk("ld_wen", 64'(w_en), 64'(j < LC));
      chk("ld_waddr", 64'(w_addr), 64'(wa0 + j));
      chk("ld_kerload", 64'(ker_load), (j == 0) ? 64'(0) : 64'(1 << (LC - j)));
      chk("ld_bias", 64'(bias_en), 64'((j == 0) && bias));
      chk("ld_acc", 64'(accum_en), 64'(0));
      tick();
    end
    chk("ld_acc_on", 64'(accum_en), 64'(1));
    chk("ld_kerload_off", 64'(ker_load), 64'(0));
  endtask

  // Randomly-paced layer run checked against the event model
  task automatic run_layer(input int c, input int k, input int t, input int kpb, input int tpb,
                           input int abort_tile);
    logic [63:0] obs;
    bit have, done, aborted, pw, pd, await_acc;
    int run, cyc;
    build_model(c, k, t, kpb, tpb);
    set_cfg(c, k, t, kpb, tpb);
    start = 1'b1;
    tick();
    start = 1'b0;
    pw = 0; pd = 0; run = 0; await_acc = 0; done = 0; aborted = 0; cyc = 0;
    while (!done && cyc < 20000) begin
      have = 0;
      obs = '0;
      if (dram_req && !pd) begin obs = mk_ev(EV_DRAM, 0, 0, int'(w_addr), 0, 1'b0); have = 1; end
      if (w_en && !pw) begin
        obs = mk_ev(EV_LOAD, int'(tile_idx), int'(ker_idx), int'(w_addr), int'(bias_addr), bias_en);
        have = 1;
      end
      if (ker_change)  begin obs = mk_ev(EV_KCHG, int'(tile_idx), int'(ker_idx), 0, 0, 1'b0); have = 1; end
      if (tile_change) begin obs = mk_ev(EV_TCHG, int'(tile_idx), int'(ker_idx), 0, 0, 1'b0); have = 1; end
      if (layer_done)  begin obs = mk_ev(EV_DONE, int'(tile_idx), int'(ker_idx), 0, 0, 1'b0); have = 1; end
      if (have) begin
        if (exp_q.size() == 0) chk("ev_extra", obs, 64'(0));
        else                   chk("ev", obs, exp_q.pop_front());
      end
      chk("ker_load", 64'(ker_load), pw ? 64'(1 << (LC - run)) : 64'(0));
      if (await_acc) begin chk("load_len", 64'(accum_en), 64'(1)); await_acc = 0; end
      if (pw && !w_en) begin
        chk("wen_len", 64'(run), 64'(LC));
        chk("load_tail", 64'(accum_en), 64'(0));
        await_acc = 1;
      end
      run = w_en ? (pw ? run + 1 : 1) : 0;
      pw = w_en;
      pd = dram_req;
      if (layer_done) begin chk("busy_done", 64'(busy), 64'(1)); done = 1; end
      if (abort_tile >= 0 && accum_en && int'(tile_idx) == abort_tile) begin
        rst_n = 1'b0;
        #1;
        chk("abort_outs", outs_vec(), 64'(0));
        aborted = 1; done = 1;
      end
      if (done) begin
        zero_inputs();
      end else begin
        dram_done = dram_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        acc_done  = accum_en ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        out_ready = ($urandom_range(0, 2) != 0);
        start     = ($urandom_range(0, 15) == 0);
        set_cfg(int'($urandom_range(0, 63)), int'($urandom_range(0, 8191)),
                int'($urandom_range(0, 511)), int'($urandom_range(0, 8191)),
                int'($urandom_range(0, 511)));
      end
      tick();
      cyc++;
    end
    if (!done) chk("timeout", 64'(0), 64'(1));
    zero_inputs();
    if (aborted) begin
      rst_n = 1'b1;
      tick();
      chk("abort_idle", outs_vec(), 64'(0));
    end else begin
      tick();
      chk("idle_busy", 64'(busy), 64'(0));
      chk("done_once", 64'(layer_done), 64'(0));
      chk("ev_left", 64'(exp_q.size()), 64'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    zero_inputs();
    repeat (3) tick();
    chk("reset_outs", outs_vec(), 64'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_outs", outs_vec(), 64'(0));

    // Two channel groups, one kernel, one tile, cycle by cycle
    set_cfg(2, 1, 1, 1, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    set_cfg(0, 0, 0, 0, 0);
    chk("a_dram", 64'(dram_req), 64'(1));
    chk("a_busy", 64'(busy), 64'(1));
    chk("a_waddr0", 64'(w_addr), 64'(0));
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("a_dram_hold", 64'(dram_req), 64'(1));
    dram_done = 1'b1;
    tick();
    dram_done = 1'b0;
    check_load(0, 1'b1);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    check_load(LC, 1'b0);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("a_kchg", 64'(ker_change), 64'(1));
    tick();
    chk("a_tchg", 64'(tile_change), 64'(1));
    chk("a_kchg_off", 64'(ker_change), 64'(0));
    tick();
    chk("a_done", 64'(layer_done), 64'(1));
    tick();
    chk("a_done_once", 64'(layer_done), 64'(0));
    chk("a_idle", 64'(busy), 64'(0));

    // Kernel buffer refill held off by out_ready
    set_cfg(1, 4, 1, 2, 1);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    dram_done = 1'b1;
    tick();
    dram_done = 1'b0;
    check_load(0, 1'b1);
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("b_kchg0", 64'(ker_change), 64'(1));
    tick();
    chk("b_ker1", 64'(ker_idx), 64'(1));
    check_load(LC, 1'b1);
    out_ready = 1'b0;
    acc_done = 1'b1;
    tick();
    acc_done = 1'b0;
    chk("b_kchg1", 64'(ker_change), 64'(1));
    chk("b_kidx1", 64'(ker_idx), 64'(1));
    repeat (3) begin
      tick();
      chk("b_hold_kchg", 64'(ker_change), 64'(0));
      chk("b_hold_dram", 64'(dram_req), 64'(0));
      chk("b_hold_kidx", 64'(ker_idx), 64'(2));
      chk("b_hold_busy", 64'(busy), 64'(1));
    end
    out_ready = 1'b1;
    tick();
    chk("b_refill", 64'(dram_req), 64'(1));
    chk("b_waddr_clr", 64'(w_addr), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("b_rst_outs", outs_vec(), 64'(0));
    zero_inputs();
    tick();
    rst_n = 1'b1;
    tick();

    run_layer(2, 1, 1, 1, 1, -1);
    run_layer(1, 2, 3, 2, 3, -1);
    run_layer(0, 2, 2, 1, 1, -1);
    run_layer(1, 1, 3, 1, 3, 1);
    run_layer(1, 1, 3, 1, 3, -1);
    run_layer(3, 5, 3, 2, 2, -1);
    repeat (12) begin
      run_layer(int'($urandom_range(0, 3)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 4)), -1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

Interface
REQ-001 Parameter CH_W, default 6: channel-group counter width.
REQ-002 Parameter KER_W, default 13: kernel counter width.
REQ-003 Parameter TILE_W, default 9: tile counter width.
REQ-004 Parameter WADDR_W, default 13: weight-memory address width.
REQ-005 Parameter LOAD_CYC, default 3: weight rows loaded into the PE per channel group.
REQ-006 clk  in  1  clock; rst_n  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle layer start pulse.
REQ-008 cfg_max_ch  in  CH_W; cfg_max_ker  in  KER_W; cfg_max_tile  in  TILE_W: counts per layer.
REQ-009 cfg_ker_per_buf  in  KER_W; cfg_tile_per_buf  in  TILE_W: kernels/tiles resident on-chip per DRAM fill.
REQ-010 dram_done  in  1: DRAM fill complete. acc_done  in  1: accumulator finished the channel group. out_ready  in  1: output buffer can accept a DRAM-bound drain.
REQ-011 dram_req  out  1; accum_en  out  1; busy  out  1; layer_done  out  1 (pulse).
REQ-012 ker_load  out  LOAD_CYC: one-hot PE row-load strobe.
REQ-013 w_addr  out  WADDR_W; w_en  out  1; bias_addr  out  KER_W; bias_en  out  1.
REQ-014 ker_idx  out  KER_W; tile_idx  out  TILE_W; ker_change  out  1; tile_change  out  1.

Function
REQ-015 States SHALL be IDLE, DRAM, LOAD, ACCUM, KER_END, TILE_END, DONE.
REQ-016 cfg_* SHALL be registered on start in IDLE; a zero count SHALL be treated as 1; start outside IDLE SHALL be ignored.
REQ-017 IDLE->DRAM on start; all counters, w_addr, kcnt and tcnt SHALL clear.
REQ-018 DRAM: dram_req=1; on dram_done -> LOAD; w_addr SHALL clear on entry.
REQ-019 LOAD SHALL last exactly LOAD_CYC+1 cycles; w_en=1 in its first LOAD_CYC cycles; w_addr SHALL increment once per w_en cycle (wrapping at 2^WADDR_W).
REQ-020 ker_load SHALL be registered: bit (LOAD_CYC-1-k) is high in the cycle after the k-th w_en cycle, otherwise 0.
REQ-021 bias_en SHALL be high in the first LOAD cycle when ch==0; bias_addr=ker_idx.
REQ-022 LOAD->ACCUM after its last cycle; accum_en=1 throughout ACCUM.
REQ-023 ACCUM on acc_done: ch<cfg_max_ch-1 -> ch+1, LOAD; otherwise -> KER_END.
REQ-024 KER_END: ker_change=1 for one cycle; ch clears.
- if ker_idx==cfg_max_ker-1 -> TILE_END;
- else ker_idx+1; if kcnt==cfg_ker_per_buf-1: kcnt->0, wait for out_ready, then -> DRAM;
- else kcnt+1 -> LOAD.
REQ-025 While waiting for out_ready, the FSM SHALL stay in KER_END/TILE_END with ker_change/tile_change pulsed only once and no counter advancing again.
REQ-026 TILE_END: tile_change=1 once; ker_idx and kcnt clear.
- if tile_idx==cfg_max_tile-1 -> DONE;
- else tile_idx+1; refetch (out_ready-gated -> DRAM, tcnt->0) if tcnt==cfg_tile_per_buf-1 or cfg_max_ker>cfg_ker_per_buf;
- else tcnt+1, w_addr->0, -> LOAD.
REQ-027 DONE: layer_done=1 for one cycle -> IDLE; busy=1 in every state except IDLE.
REQ-028 acc_done outside ACCUM and dram_done outside DRAM SHALL be ignored.

Reset
REQ-029 On rst_n low, at any time including mid-layer, state=IDLE and every output and counter SHALL be 0; operation restarts only on a fresh start.

Verification
REQ-030 max_ch=2, max_ker=1, max_tile=1, bufs=1: start, dram_done -> LOAD(4 cycles) -> ACCUM -> LOAD -> ACCUM -> KER_END -> TILE_END -> DONE; exactly one layer_done pulse.
REQ-031 LOAD_CYC=3: ker_load 100,010,001 in the cycles following w_en; w_addr steps 0->3 over the first LOAD and 3->6 over the second.
REQ-032 max_ker=4, ker_per_buf=2, out_ready=0 at kernel 1 end: FSM holds in KER_END, ker_change pulses once; out_ready=1 -> DRAM, w_addr cleared.
REQ-033 max_tile=3, tile_per_buf=3, max_ker=ker_per_buf=2: no dram_req after the initial fill; tile_idx 0,1,2 -> layer_done.
REQ-034 rst_n asserted during ACCUM at tile 1: all outputs 0 immediately; later start runs a full layer from tile 0.
REQ-035 cfg_max_ch=0, start during busy: behaves as max_ch=1; second start has no effect.
